// File: rtl/robs_pkg.sv
// Shared definitions for the Robertson-style signed divider.
//   div_state_t : divider FSM states (IDLE, ITER, FIX, DONE)
//   most_neg()  : most-negative two's-complement value for a given width,
//                 returned zero-extended to 64 bits
package robs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic logic [63:0] most_neg(input int width);
        return 64'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/robs_div_step.sv
// One combinational restoring-division step on magnitudes.
//   a_i [WIDTH:0]   : partial remainder A before the step
//   q_i [WIDTH-1:0] : dividend/quotient shift register Q before the step
//   m_i [WIDTH-1:0] : divisor magnitude M
//   a_o, q_o        : A and Q after shift, trial subtract and select
module robs_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // One extra bit beyond A keeps the trial difference's sign unambiguous.
    assign shifted = {a_i, q_i[WIDTH-1]};
    assign trial   = shifted - {2'b00, m_i};

    always_comb begin
        a_o = shifted[WIDTH:0];
        q_o = {q_i[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            a_o = trial[WIDTH:0];
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/robs_divider.sv
// Sequential signed divider: restoring division on operand magnitudes,
// followed by a sign-fix step (rounds toward zero, remainder takes the
// dividend's sign).
//   clk, reset             : clock, synchronous active-high reset
//   start                  : request, sampled only in IDLE
//   dividend, divisor      : signed operands, captured on the accepting edge
//   quotient, remainder    : registered signed results
//   busy                   : state != IDLE
//   done                   : one-cycle pulse when results are valid
//   div_by_zero, overflow  : result flags, updated together with results
//   state_o                : current FSM state (debug)
// Handshake: a request is accepted on the edge where start=1 and the FSM is
// IDLE; any start seen while busy (including the DONE cycle) is ignored.
import robs_pkg::*;

module robs_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow,
    output div_state_t       state_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

    div_state_t       state_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q, m_q;
    logic [WIDTH-1:0] dvd_q, dvs_q;
    logic             sign_q_q, sign_r_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             done_q, dz_q, ov_q;

    logic [WIDTH:0]   a_d;
    logic [WIDTH-1:0] q_d;

    robs_div_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (a_d),
        .q_o (q_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Magnitude of the most-negative value fits unsigned.
                        q_q      <= dividend[WIDTH-1] ? -dividend : dividend;
                        m_q      <= divisor[WIDTH-1]  ? -divisor  : divisor;
                        a_q      <= '0;
                        dvd_q    <= dividend;
                        dvs_q    <= divisor;
                        sign_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_q <= dividend[WIDTH-1];
                        cnt_q    <= CW'(WIDTH);
                        dz_q     <= 1'b0;
                        ov_q     <= 1'b0;
                        state_q  <= (divisor == '0) ? FIX : ITER;
                    end
                end
                ITER: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (dvs_q == '0) begin
                        quot_q <= '1;
                        rem_q  <= dvd_q;
                        dz_q   <= 1'b1;
                    end else begin
                        // MOST_NEG / -1 wraps naturally: |Q| = 2^(W-1), negated stays put.
                        quot_q <= sign_q_q ? -q_q : q_q;
                        rem_q  <= sign_r_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
                        ov_q   <= (dvd_q == MOST_NEG) && (dvs_q == '1);
                    end
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_robs_divider.sv
// Directed bench for robs_divider (WIDTH=8): vector table plus hand-written
// sequences for start-while-busy and reset-mid-operation.
import robs_pkg::*;

module tb_robs_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_by_zero, overflow;
    div_state_t   state_o;

    int errors = 0;
    int checks = 0;

    robs_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        logic         exp_dz;
        logic         exp_ov;
        int           exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for done (sampled 1ns after each edge); reports edges counted
    // from the most recent edge. busy must stay high until done shows up.
    task automatic wait_done(input string name, output int edges);
        bit busy_ok = 1'b1;
        edges = 0;
        while (!done && edges < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        check({name, " done seen"}, 32'(done), 32'd1);
        check({name, " busy before done"}, 32'(busy_ok), 32'd1);
    endtask

    // Issues one request from IDLE; start dropped right after the accepting edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int edges);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("op", edges);
    endtask

    initial begin
        int lat;

        vecs.push_back('{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 9});
        vecs.push_back('{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 9});
        vecs.push_back('{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 9});
        vecs.push_back('{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 9});
        vecs.push_back('{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 9});
        vecs.push_back('{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{8'd5,   8'd9,   8'h00, 8'h05, 1'b0, 1'b0, 9});
        vecs.push_back('{8'd55,  8'd0,   8'hFF, 8'h37, 1'b1, 1'b0, 1});
        vecs.push_back('{8'd127, 8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 9});
        vecs.push_back('{8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{8'h80,  8'd0,   8'hFF, 8'h80, 1'b1, 1'b0, 1});
        vecs.push_back('{8'hFB,  8'd2,   8'hFE, 8'hFF, 1'b0, 1'b0, 9});

        // Clock/reset
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset dz", 32'(div_by_zero), 32'd0);
        check("reset ov", 32'(overflow), 32'd0);
        check("reset state", 32'(state_o), 32'(IDLE));

        // Table-driven vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].dvd, vecs[i].dvs, lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d quotient", i), 32'(quotient), 32'(vecs[i].exp_q));
            check($sformatf("v%0d remainder", i), 32'(remainder), 32'(vecs[i].exp_r));
            check($sformatf("v%0d dz", i), 32'(div_by_zero), 32'(vecs[i].exp_dz));
            check($sformatf("v%0d ov", i), 32'(overflow), 32'(vecs[i].exp_ov));
            @(posedge clk); #1;
            check($sformatf("v%0d done one cycle", i), 32'(done), 32'd0);
            check($sformatf("v%0d idle after", i), 32'(busy), 32'd0);
            check($sformatf("v%0d hold quotient", i), 32'(quotient), 32'(vecs[i].exp_q));
        end

        // start held high with changing operands while busy
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!done && lat < 40) begin
            dividend = 8'($urandom_range(1, 255));
            divisor  = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
            lat++;
        end
        check("busy-start done seen", 32'(done), 32'd1);
        check("busy-start latency", 32'(lat), 32'd9);
        check("busy-start quotient", 32'(quotient), 32'h0E);
        check("busy-start remainder", 32'(remainder), 32'h02);
        dividend = 8'd50;
        divisor  = 8'd5;
        @(posedge clk); #1;
        check("busy-start done ignored", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy-start second accepted", 32'(busy), 32'd1);
        wait_done("second", lat);
        check("second latency", 32'(lat), 32'd9);
        check("second quotient", 32'(quotient), 32'h0A);
        check("second remainder", 32'(remainder), 32'h00);

        // reset on the 4th ITER edge
        @(posedge clk); #1;
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort state", 32'(state_o), 32'(IDLE));
        check("abort busy", 32'(busy), 32'd0);
        check("abort quotient", 32'(quotient), 32'd0);
        check("abort remainder", 32'(remainder), 32'd0);
        check("abort done", 32'(done), 32'd0);
        begin
            bit saw_done = 1'b0;
            repeat (15) begin
                @(posedge clk); #1;
                if (done) saw_done = 1'b1;
            end
            check("abort no done", 32'(saw_done), 32'd0);
        end
        run_op(8'd50, 8'd5, lat);
        check("post-abort latency", 32'(lat), 32'd9);
        check("post-abort quotient", 32'(quotient), 32'h0A);
        check("post-abort remainder", 32'(remainder), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
